// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// parameter defaults, the all-zero instruction constant and an address
// alignment helper.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam int          DEFAULT_DEPTH    = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] ZERO_INSTR       = 32'h0000_0000;

   // Fetch addresses are word aligned; the two low bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory port, the redirect/stall controls and the
// decode-stage outputs of the fetch unit.
//   master : fetch unit side (drives imem_req/imem_addr and id_*)
//   slave  : environment side (memory, branch unit, decode stage)
//
// Handshake: imem_req and imem_ack are single-cycle strobes, not valid/ready.
// A request is taken at the rising edge where imem_req=1 (imem_addr valid in
// that cycle); the memory answers with exactly one imem_ack pulse, carrying
// imem_rdata, no earlier than the cycle after the request. On the decode side
// the head entry (id_valid=1) retires at a rising edge where stall=0.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_npc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc, id_npc,
      input  imem_ack, imem_rdata, redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_npc,
      output imem_ack, imem_rdata, redirect, redirect_pc, stall
   );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Pointer-based FIFO of {pc, instr} pairs feeding the decode stage.
// Ports:
//   clc, reset            clock, asynchronous active-low reset
//   push, push_pc/instr   write an entry at the tail
//   pop                   retire the head entry
//   flush                 empty the queue and zero both pointers (wins)
//   head_pc/head_instr    head entry contents (meaningful when count!=0)
//   count                 number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clc,
   input  logic          reset,
   input  logic          push,
   input  logic [31:0]   push_pc,
   input  logic [31:0]   push_instr,
   input  logic          pop,
   input  logic          flush,
   output logic [31:0]   head_pc,
   output logic [31:0]   head_instr,
   output logic [CW-1:0] count
);

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Guards keep the pointers sane even if a caller misbehaves; the fetch
   // unit never pushes into a full queue or pops an empty one.
   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);

   always_ff @(posedge clc or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed while count says so.
   always_ff @(posedge clc) begin
      if (do_push && !flush) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Sequential instruction prefetcher with a DEPTH-entry queue toward decode.
// Ports:
//   clc        clock (rising edge)
//   reset      asynchronous active-low reset
//   bus        instr_fetch_unit_if.master: imem request/ack, redirect, stall,
//              decode-stage head entry (id_valid/id_instr/id_pc/id_npc)
//   fsm_state  current fetch FSM state, for observation
// At most one memory request is in flight. A redirect flushes the queue,
// reloads the fetch address and, if a request is still outstanding, moves
// to DISCARD so the stale answer is dropped.
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                clc,
   input  logic                reset,
   instr_fetch_unit_if.master  bus,
   output fetch_state_t        fsm_state
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   fetch_state_t  state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          run;
   logic          issue;
   logic          push;
   logic          pop;
   logic          id_valid;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;
   logic [CW-1:0] count;

   // run stays low until the first edge after reset release so that no
   // request is presented while reset is asserted or in the release cycle.
   always_ff @(posedge clc or negedge reset) begin
      if (!reset) run <= 1'b0;
      else        run <= 1'b1;
   end

   always_ff @(posedge clc or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            // No request is outstanding in IDLE, so a free slot now is a
            // slot reserved for the word this request brings back.
            if (run && !bus.redirect && (count < CW'(DEPTH))) begin
               issue     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_ack) begin
               push      = !bus.redirect;
               state_nxt = IDLE;
            end else if (bus.redirect) begin
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            if (bus.imem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clc or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else if (bus.redirect) begin
         fetch_pc <= word_align(bus.redirect_pc);
      end else if (issue) begin
         req_pc   <= fetch_pc;
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   assign id_valid = (count != '0);
   assign pop      = id_valid && !bus.stall && !bus.redirect;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clc        (clc),
      .reset      (reset),
      .push       (push),
      .push_pc    (req_pc),
      .push_instr (bus.imem_rdata),
      .pop        (pop),
      .flush      (bus.redirect),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (count)
   );

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc;
   assign bus.id_valid  = id_valid;
   assign bus.id_instr  = id_valid ? head_instr       : ZERO_INSTR;
   assign bus.id_pc     = id_valid ? head_pc          : 32'd0;
   assign bus.id_npc    = id_valid ? head_pc + 32'd4  : 32'd0;
   assign fsm_state     = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit: table-driven cycle vectors plus
// hand-written redirect / wrap / reset sequences. Inputs change on the
// falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   typedef struct {
      logic        rd;
      logic [31:0] rpc;
      logic        st;
      logic        ack;
      logic [31:0] raddr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_pc;
   } vec_t;

   logic         clc;
   logic         reset;
   fetch_state_t fsm_state;
   int           n_cmp;
   int           n_bad;
   logic [31:0]  exp_q[$];
   vec_t         tbl_a[9];
   vec_t         tbl_b[17];

   instr_fetch_unit_if bus ();

   instr_fetch_unit dut (
      .clc       (clc),
      .reset     (reset),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clc = 1'b0;
      forever #5 clc = ~clc;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] word_for(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic st,
                               input logic ack, input logic [31:0] raddr,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_val, input logic [31:0] e_pc);
      vec_t r;
      r.rd = rd; r.rpc = rpc; r.st = st; r.ack = ack; r.raddr = raddr;
      r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic late_ack);
      @(negedge clc);
      reset           = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.stall       = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'd0;
      #1;
      chk("reset imem_req", 32'(bus.imem_req), 32'd0);
      chk("reset state", 32'(fsm_state), 32'(IDLE));
      chk("reset id_valid", 32'(bus.id_valid), 32'd0);
      @(negedge clc);
      #1;
      chk("reset id_instr", bus.id_instr, 32'd0);
      chk("reset id_pc", bus.id_pc, 32'd0);
      chk("reset id_npc", bus.id_npc, 32'd0);
      @(negedge clc);
      reset          = 1'b1;
      bus.imem_ack   = late_ack;
      bus.imem_rdata = 32'hBAD0_BAD0;
      #1;
      chk("release imem_req", 32'(bus.imem_req), 32'd0);
      chk("release id_valid", 32'(bus.id_valid), 32'd0);
   endtask

   task automatic drive_check(input vec_t r, input string tag, input int idx);
      logic [31:0] e_instr;
      logic [31:0] e_npc;
      logic [31:0] e_pc;
      @(negedge clc);
      bus.redirect    = r.rd;
      bus.redirect_pc = r.rpc;
      bus.stall       = r.st;
      bus.imem_ack    = r.ack;
      bus.imem_rdata  = word_for(r.raddr);
      #1;
      e_pc    = r.e_val ? r.e_pc : 32'd0;
      e_instr = r.e_val ? word_for(r.e_pc) : 32'd0;
      e_npc   = r.e_val ? r.e_pc + 32'd4 : 32'd0;
      chk($sformatf("%s[%0d] imem_req", tag, idx), 32'(bus.imem_req), 32'(r.e_req));
      if (r.e_req)
         chk($sformatf("%s[%0d] imem_addr", tag, idx), bus.imem_addr, r.e_addr);
      chk($sformatf("%s[%0d] id_valid", tag, idx), 32'(bus.id_valid), 32'(r.e_val));
      chk($sformatf("%s[%0d] id_pc", tag, idx), bus.id_pc, e_pc);
      chk($sformatf("%s[%0d] id_instr", tag, idx), bus.id_instr, e_instr);
      chk($sformatf("%s[%0d] id_npc", tag, idx), bus.id_npc, e_npc);
      // Retirement scoreboard: expected retire order against observed order.
      if (r.e_val && !r.st && !r.rd) exp_q.push_back(r.e_pc);
      if (bus.id_valid && !bus.stall && !bus.redirect) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s[%0d] retire: got pc %h, expected no retirement", tag, idx, bus.id_pc);
         end else begin
            chk($sformatf("%s[%0d] retire_order", tag, idx), bus.id_pc, exp_q.pop_front());
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp           = 0;
      n_bad           = 0;
      reset           = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.stall       = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'd0;

      // Sequential fetch, 1-cycle memory, no stall.
      tbl_a[0] = mk(0, 0, 0, 0, 0,  1, 32'd0,  0, 0);
      tbl_a[1] = mk(0, 0, 0, 1, 0,  0, 0,      0, 0);
      tbl_a[2] = mk(0, 0, 0, 0, 0,  1, 32'd4,  1, 32'd0);
      tbl_a[3] = mk(0, 0, 0, 1, 4,  0, 0,      0, 0);
      tbl_a[4] = mk(0, 0, 0, 0, 0,  1, 32'd8,  1, 32'd4);
      tbl_a[5] = mk(0, 0, 0, 1, 8,  0, 0,      0, 0);
      tbl_a[6] = mk(0, 0, 0, 0, 0,  1, 32'd12, 1, 32'd8);
      tbl_a[7] = mk(0, 0, 0, 1, 12, 0, 0,      0, 0);
      tbl_a[8] = mk(0, 0, 0, 0, 0,  1, 32'd16, 1, 32'd12);

      // Stall for 10 cycles: queue fills to 4, requests stop, then drain.
      tbl_b[0]  = mk(0, 0, 1, 0, 0,  1, 32'd0,  0, 0);
      tbl_b[1]  = mk(0, 0, 1, 1, 0,  0, 0,      0, 0);
      tbl_b[2]  = mk(0, 0, 1, 0, 0,  1, 32'd4,  1, 32'd0);
      tbl_b[3]  = mk(0, 0, 1, 1, 4,  0, 0,      1, 32'd0);
      tbl_b[4]  = mk(0, 0, 1, 0, 0,  1, 32'd8,  1, 32'd0);
      tbl_b[5]  = mk(0, 0, 1, 1, 8,  0, 0,      1, 32'd0);
      tbl_b[6]  = mk(0, 0, 1, 0, 0,  1, 32'd12, 1, 32'd0);
      tbl_b[7]  = mk(0, 0, 1, 1, 12, 0, 0,      1, 32'd0);
      tbl_b[8]  = mk(0, 0, 1, 0, 0,  0, 0,      1, 32'd0);
      tbl_b[9]  = mk(0, 0, 1, 0, 0,  0, 0,      1, 32'd0);
      tbl_b[10] = mk(0, 0, 0, 0, 0,  0, 0,      1, 32'd0);
      tbl_b[11] = mk(0, 0, 0, 0, 0,  1, 32'd16, 1, 32'd4);
      tbl_b[12] = mk(0, 0, 0, 1, 16, 0, 0,      1, 32'd8);
      tbl_b[13] = mk(0, 0, 0, 0, 0,  1, 32'd20, 1, 32'd12);
      tbl_b[14] = mk(0, 0, 0, 0, 0,  0, 0,      1, 32'd16);
      tbl_b[15] = mk(0, 0, 0, 1, 20, 0, 0,      0, 0);
      tbl_b[16] = mk(0, 0, 0, 0, 0,  1, 32'd24, 1, 32'd20);

      do_reset(1'b0);
      for (int i = 0; i < 9; i++) drive_check(tbl_a[i], "seq", i);

      do_reset(1'b0);
      for (int i = 0; i < 17; i++) drive_check(tbl_b[i], "stall", i);

      // Redirect while WAIT with a non-empty queue; the late ack is dropped.
      do_reset(1'b0);
      drive_check(mk(0, 0, 1, 0, 0,          1, 32'd0,  0, 0), "redir_wait", 0);
      drive_check(mk(0, 0, 1, 1, 0,          0, 0,      0, 0), "redir_wait", 1);
      drive_check(mk(0, 0, 1, 0, 0,          1, 32'd4,  1, 32'd0), "redir_wait", 2);
      drive_check(mk(1, 32'h40, 1, 0, 0,     0, 0,      1, 32'd0), "redir_wait", 3);
      drive_check(mk(0, 0, 0, 0, 0,          0, 0,      0, 0), "redir_wait", 4);
      drive_check(mk(0, 0, 0, 0, 0,          0, 0,      0, 0), "redir_wait", 5);
      drive_check(mk(0, 0, 0, 1, 4,          0, 0,      0, 0), "redir_wait", 6);
      drive_check(mk(0, 0, 0, 0, 0,          1, 32'h40, 0, 0), "redir_wait", 7);
      drive_check(mk(0, 0, 0, 1, 32'h40,     0, 0,      0, 0), "redir_wait", 8);
      drive_check(mk(0, 0, 0, 0, 0,          1, 32'h44, 1, 32'h40), "redir_wait", 9);

      // Redirect coincident with ack and pop.
      do_reset(1'b0);
      drive_check(mk(0, 0, 0, 0, 0,          1, 32'd0,   0, 0), "redir_ack", 0);
      drive_check(mk(0, 0, 0, 1, 0,          0, 0,       0, 0), "redir_ack", 1);
      drive_check(mk(0, 0, 1, 0, 0,          1, 32'd4,   1, 32'd0), "redir_ack", 2);
      drive_check(mk(1, 32'h100, 0, 1, 4,    0, 0,       1, 32'd0), "redir_ack", 3);
      drive_check(mk(0, 0, 0, 0, 0,          1, 32'h100, 0, 0), "redir_ack", 4);
      drive_check(mk(0, 0, 0, 1, 32'h100,    0, 0,       0, 0), "redir_ack", 5);
      drive_check(mk(0, 0, 0, 0, 0,          1, 32'h104, 1, 32'h100), "redir_ack", 6);

      // Redirect in IDLE suppresses the request; low bits ignored; address wraps.
      do_reset(1'b0);
      drive_check(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,              0, 0), "wrap", 0);
      drive_check(mk(0, 0, 0, 0, 0,             1, 32'hFFFF_FFFC,  0, 0), "wrap", 1);
      drive_check(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0,              0, 0), "wrap", 2);
      drive_check(mk(0, 0, 0, 0, 0,             1, 32'd0,          1, 32'hFFFF_FFFC), "wrap", 3);
      drive_check(mk(0, 0, 0, 1, 0,             0, 0,              0, 0), "wrap", 4);
      drive_check(mk(0, 0, 0, 0, 0,             1, 32'd4,          1, 32'd0), "wrap", 5);

      // Reset during WAIT; the abandoned request's ack arrives after release.
      do_reset(1'b0);
      drive_check(mk(0, 0, 0, 0, 0, 1, 32'd0, 0, 0), "rst_wait", 0);
      do_reset(1'b1);
      drive_check(mk(0, 0, 0, 0, 0, 1, 32'd0, 0, 0), "rst_wait", 1);
      drive_check(mk(0, 0, 0, 1, 0, 0, 0,     0, 0), "rst_wait", 2);
      drive_check(mk(0, 0, 0, 0, 0, 1, 32'd4, 1, 32'd0), "rst_wait", 3);

      // ---------------- final report ----------------
      chk("scoreboard leftover", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: prefetch queue entries, power of two, ≥2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clc  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 imem_req  output  1  one-cycle read request strobe to instruction memory.
REQ-006 imem_addr  output  32  byte address of request, bits[1:0]=00, valid while imem_req=1.
REQ-007 imem_ack  input  1  one-cycle strobe: imem_rdata valid; earliest one cycle after imem_req.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address; bits[1:0] ignored, treated as 00.
REQ-011 stall  input  1  downstream IF/ID not accepting (load-use hazard hold).
REQ-012 id_valid  output  1  queue head holds a valid instruction.
REQ-013 id_instr  output  32  head instruction; 0 when id_valid=0.
REQ-014 id_pc  output  32  head instruction address; 0 when id_valid=0.
REQ-015 id_npc  output  32  id_pc+4 mod 2^32; 0 when id_valid=0.

Function
REQ-016 FSM states IDLE, WAIT, DISCARD; at most one request outstanding.
REQ-017 IDLE: if redirect=0 and count<DEPTH, assert imem_req with imem_addr=fetch_pc, fetch_pc+=4 (wraps at 2^32), go WAIT.
REQ-018 WAIT: on imem_ack push {fetch address, imem_rdata} to queue tail, go IDLE; next request no earlier than following cycle.
REQ-019 Slot reservation: IDLE issues only if count+0 < DEPTH; an issued request's slot is guaranteed, so push never meets a full queue.
REQ-020 Pop: when id_valid=1 and stall=0, head entry retires at the edge; stall=1 holds head and outputs unchanged.
REQ-021 Push and pop in the same cycle leave count unchanged; data ordering strictly FIFO.
REQ-022 redirect=1 (any state): queue flushed (count=0, pointers 0), fetch_pc=redirect_pc, no imem_req that cycle, id_valid=0 next cycle.
REQ-023 redirect in WAIT without imem_ack: go DISCARD; the next imem_ack is dropped, then IDLE.
REQ-024 redirect in WAIT coincident with imem_ack: returning word dropped, go IDLE.
REQ-025 redirect has priority over push, pop and issue in the same cycle.
REQ-026 imem_ack in IDLE is ignored.
REQ-027 count range 0..DEPTH; id_valid = (count!=0).

Reset
REQ-028 reset=0: state IDLE, fetch_pc=RESET_PC, count=0, pointers 0, imem_req=0, id_valid=0, id_instr/id_pc/id_npc=0.
REQ-029 Reset mid-WAIT abandons the request; a late imem_ack after release arrives in IDLE and is ignored.
REQ-030 First imem_req no earlier than the first rising edge after reset release.

Structure
REQ-031 Shared package holds FSM state enum, DEPTH default, RESET_PC default and the 32-bit zero instruction constant.
REQ-032 One sub-module, fetch_fifo: pointer FIFO of {pc, instr} with push/pop/flush and count output.

Verification
REQ-033 Reset release, imem_ack 1 cycle after every req, stall=0 -> addresses 0,4,8,12 requested; id_pc sequence 0,4,8,12 matching words.
REQ-034 stall held 10 cycles with 1-cycle memory -> exactly 4 words queued, imem_req stays 0 while count=4, head unchanged; release drains in order.
REQ-035 redirect to 32'h40 while WAIT, ack 3 cycles later -> acked word dropped, next imem_addr=32'h40, id_valid=0 until its ack.
REQ-036 redirect coincident with imem_ack and pop -> queue empty, id_valid=0, next request at redirect_pc.
REQ-037 redirect_pc=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000; id_npc of first entry = 0.
REQ-038 reset asserted during WAIT, ack arrives after release -> ignored; first request at RESET_PC.
